// File: rtl/ip_codma_machine_states_pkg.sv
// Shared types and constants for the codma machines, including the ping-pong
// transfer buffer slot states and sizing.
package ip_codma_machine_states_pkg;

  localparam int unsigned BUF_NUM_SLOTS = 2;
  localparam int unsigned BUF_WORDS     = 8;
  localparam int unsigned BUF_WORD_W    = 32;
  localparam int unsigned BUF_CNT_W     = 4;
  localparam int unsigned BUF_BEAT_W    = 2;
  localparam int unsigned BUF_BEAT_DW   = 64;
  localparam int unsigned BUF_IDX_W     = 3;

  localparam logic [BUF_CNT_W-1:0] BUF_W2 = 4'd2;
  localparam logic [BUF_CNT_W-1:0] BUF_W6 = 4'd6;
  localparam logic [BUF_CNT_W-1:0] BUF_W8 = 4'd8;

  typedef enum logic [1:0] {
    BUF_EMPTY    = 2'b00,
    BUF_FULL     = 2'b01,
    BUF_DRAINING = 2'b10,
    BUF_UNUSED   = 2'b11
  } buf_slot_state_t;

  typedef logic [BUF_WORDS-1:0][BUF_WORD_W-1:0] buf_data_t;

  function automatic logic buf_words_legal(input logic [BUF_CNT_W-1:0] words);
    return (words == BUF_W2) || (words == BUF_W6) || (words == BUF_W8);
  endfunction

endpackage

// File: rtl/ip_codma_xfer_buffer_if.sv
// Read-capture / write-drain bundle of the codma transfer buffer.
// Optional IP_CODMA_BUF_PARITY_EN adds buf_parity_err_o.
interface ip_codma_xfer_buffer_if;
  import ip_codma_machine_states_pkg::*;

  logic                   flush_i;
  logic                   rd_done_i;
  logic [BUF_CNT_W-1:0]   rd_words_i;
  buf_data_t              rd_data_i;
  logic                   rd_ready_o;
  logic                   wr_req_o;
  logic [BUF_CNT_W-1:0]   wr_words_o;
  logic [BUF_BEAT_DW-1:0] wr_data_o;
  logic                   wr_last_o;
  logic                   wr_beat_i;
  logic                   wr_done_o;
  logic [1:0]             level_o;
  logic                   err_o;
`ifdef IP_CODMA_BUF_PARITY_EN
  logic                   buf_parity_err_o;
`endif

  modport slave (
    input  flush_i, rd_done_i, rd_words_i, rd_data_i, wr_beat_i,
    output rd_ready_o, wr_req_o, wr_words_o, wr_data_o, wr_last_o,
           wr_done_o, level_o, err_o
`ifdef IP_CODMA_BUF_PARITY_EN
    , output buf_parity_err_o
`endif
  );

  modport master (
    output flush_i, rd_done_i, rd_words_i, rd_data_i, wr_beat_i,
    input  rd_ready_o, wr_req_o, wr_words_o, wr_data_o, wr_last_o,
           wr_done_o, level_o, err_o
`ifdef IP_CODMA_BUF_PARITY_EN
    , input buf_parity_err_o
`endif
  );

endinterface

// File: rtl/ip_codma_buf_slot.sv
// One staging slot: 8x32 data, word count, slot state and beat read-out mux.
// Optional IP_CODMA_BUF_PARITY_EN stores and checks per-word even parity.
module ip_codma_buf_slot
  import ip_codma_machine_states_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   flush_i,
  input  logic                   cap_i,
  input  logic [BUF_CNT_W-1:0]   cap_words_i,
  input  buf_data_t              cap_data_i,
  input  logic                   beat_i,
  input  logic                   last_i,
  input  logic [BUF_BEAT_W-1:0]  beat_idx_i,
  output buf_slot_state_t        state_o,
  output buf_slot_state_t        nxt_state_o,
  output logic [BUF_CNT_W-1:0]   words_o,
  output logic [BUF_BEAT_DW-1:0] data_o,
  output logic                   illegal_o
`ifdef IP_CODMA_BUF_PARITY_EN
  , output logic                 par_err_o
`endif
);

  buf_slot_state_t      state_q, state_d;
  buf_data_t            data_q, data_d;
  logic [BUF_CNT_W-1:0] words_q, words_d;
  logic [BUF_IDX_W-1:0] lo_idx, hi_idx;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    words_d = words_q;
    if (cap_i) begin
      data_d  = cap_data_i;
      words_d = cap_words_i;
    end
    if (flush_i) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY:    if (cap_i) state_d = BUF_FULL;
        BUF_FULL:     if (beat_i) state_d = last_i ? BUF_EMPTY : BUF_DRAINING;
        BUF_DRAINING: if (beat_i && last_i) state_d = BUF_EMPTY;
        default:      state_d = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= BUF_EMPTY;
    else            state_q <= state_d;
  end

  // Payload is not reset; it is only observable while the slot is occupied.
  always_ff @(posedge clk_i) begin
    data_q  <= data_d;
    words_q <= words_d;
  end

  assign lo_idx      = {beat_idx_i, 1'b0};
  assign hi_idx      = {beat_idx_i, 1'b1};
  assign state_o     = state_q;
  assign nxt_state_o = state_d;
  assign words_o     = words_q;
  assign data_o      = {data_q[hi_idx], data_q[lo_idx]};
  assign illegal_o   = (state_q == BUF_UNUSED);

`ifdef IP_CODMA_BUF_PARITY_EN
  logic [BUF_WORDS-1:0] par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (cap_i) begin
      for (int i = 0; i < BUF_WORDS; i++) par_d[i] = ^cap_data_i[i];
    end
  end

  always_ff @(posedge clk_i) par_q <= par_d;

  assign par_err_o = beat_i && (((^data_q[lo_idx]) != par_q[lo_idx]) ||
                                ((^data_q[hi_idx]) != par_q[hi_idx]));
`endif

endmodule

// File: rtl/ip_codma_xfer_buffer.sv
// Ping-pong staging buffer between the codma read and write machines.
// Optional IP_CODMA_BUF_PARITY_EN enables per-word parity and buf_parity_err_o.
module ip_codma_xfer_buffer
  import ip_codma_machine_states_pkg::*;
(
  input logic                   clk_i,
  input logic                   reset_n_i,
  ip_codma_xfer_buffer_if.slave bus
);

  buf_slot_state_t        slot_state [BUF_NUM_SLOTS];
  buf_slot_state_t        slot_nxt   [BUF_NUM_SLOTS];
  logic [BUF_CNT_W-1:0]   slot_words [BUF_NUM_SLOTS];
  logic [BUF_BEAT_DW-1:0] slot_data  [BUF_NUM_SLOTS];
  logic [BUF_NUM_SLOTS-1:0] slot_cap, slot_beat, slot_illegal, slot_par_err;

  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BUF_BEAT_W-1:0] beat_q, beat_d;
  logic                  done_q, done_d, err_q, err_d, par_err_q, par_err_d;
  logic [1:0]            level_q, level_d;

  logic                  head_busy, wr_last_c, cap_ok, cap_err, beat_acc, underflow;
  logic                  words_ok, tgt_empty;
  logic [BUF_CNT_W-1:0]  head_words;
  logic [BUF_BEAT_W-1:0] last_idx;

  for (genvar i = 0; i < BUF_NUM_SLOTS; i++) begin : g_slot
    assign slot_cap[i]  = cap_ok && (wr_ptr_q == 1'(i));
    assign slot_beat[i] = beat_acc && (rd_ptr_q == 1'(i));

    ip_codma_buf_slot u_slot (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .flush_i     (bus.flush_i),
      .cap_i       (slot_cap[i]),
      .cap_words_i (bus.rd_words_i),
      .cap_data_i  (bus.rd_data_i),
      .beat_i      (slot_beat[i]),
      .last_i      (wr_last_c),
      .beat_idx_i  (beat_q),
      .state_o     (slot_state[i]),
      .nxt_state_o (slot_nxt[i]),
      .words_o     (slot_words[i]),
      .data_o      (slot_data[i]),
      .illegal_o   (slot_illegal[i])
`ifdef IP_CODMA_BUF_PARITY_EN
      , .par_err_o (slot_par_err[i])
`endif
    );
  end

`ifndef IP_CODMA_BUF_PARITY_EN
  assign slot_par_err = '0;
`endif

  // Head decode, capture/beat qualification and pointer/status next-state.
  always_comb begin
    head_busy  = (slot_state[rd_ptr_q] == BUF_FULL) || (slot_state[rd_ptr_q] == BUF_DRAINING);
    head_words = head_busy ? slot_words[rd_ptr_q] : '0;
    last_idx   = 2'(head_words[3:1] - 3'd1);
    wr_last_c  = head_busy && (beat_q == last_idx);
    words_ok   = buf_words_legal(bus.rd_words_i);
    tgt_empty  = (slot_state[wr_ptr_q] == BUF_EMPTY);
    cap_ok     = bus.rd_done_i && !bus.flush_i && words_ok && tgt_empty;
    cap_err    = bus.rd_done_i && !bus.flush_i && !(words_ok && tgt_empty);
    beat_acc   = bus.wr_beat_i && !bus.flush_i && head_busy;
    underflow  = bus.wr_beat_i && !bus.flush_i && !head_busy;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    beat_d    = beat_q;
    done_d    = 1'b0;
    par_err_d = 1'b0;
    err_d     = err_q;
    level_d   = 2'(slot_nxt[0] != BUF_EMPTY) + 2'(slot_nxt[1] != BUF_EMPTY);

    if (bus.flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      beat_d   = '0;
      err_d    = 1'b0;
    end else begin
      if (cap_ok) wr_ptr_d = ~wr_ptr_q;
      if (beat_acc) begin
        beat_d = wr_last_c ? '0 : 2'(beat_q + 2'd1);
        if (wr_last_c) begin
          rd_ptr_d = ~rd_ptr_q;
          done_d   = 1'b1;
        end
      end
      par_err_d = |slot_par_err;
      err_d     = err_q | cap_err | underflow | (|slot_illegal) | par_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      beat_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      par_err_q <= 1'b0;
      level_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      beat_q    <= beat_d;
      done_q    <= done_d;
      err_q     <= err_d;
      par_err_q <= par_err_d;
      level_q   <= level_d;
    end
  end

  assign bus.rd_ready_o = (level_q < 2'd2);
  assign bus.wr_req_o   = head_busy;
  assign bus.wr_words_o = head_words;
  assign bus.wr_data_o  = head_busy ? slot_data[rd_ptr_q] : '0;
  assign bus.wr_last_o  = wr_last_c;
  assign bus.wr_done_o  = done_q;
  assign bus.level_o    = level_q;
  assign bus.err_o      = err_q;
`ifdef IP_CODMA_BUF_PARITY_EN
  assign bus.buf_parity_err_o = par_err_q;
`else
  logic unused_par;
  assign unused_par = par_err_q;
`endif

endmodule

// File: doc/ip_codma_xfer_buffer.md
Name: ip_codma_xfer_buffer

Overview:
- Ping-pong staging buffer between the codma read machine and write machine.
- Captures a completed read burst: an 8x32 word register plus a valid word count.
- Presents the data to the write path as 64-bit beats in word order.
- Two slots let the next read fill one slot while the other drains to the bus.

Parameters:
- NUM_SLOTS, 2, number of staging slots; fixed at 2, a ping-pong pointer is 1 bit.
- WORDS_PER_SLOT, 8, number of 32-bit words per slot.

Ports:
- clk_i  input  1  system clock.
- reset_n_i  input  1  reset, synchronous, active-low.
- flush_i  input  1  stop/abort from the codma top; clears buffer state.
- rd_done_i  input  1  single-cycle pulse: a read burst is complete and rd_data_i is stable.
- rd_words_i  input  4  valid 32-bit words in the burst; legal values 2, 6, 8.
- rd_data_i  input  8x32  read data; word 0 is the lowest address.
- rd_ready_o  output  1  at least one slot is EMPTY.
- wr_req_o  output  1  the head slot is FULL or DRAINING; a write is needed.
- wr_words_o  output  4  word count of the head slot.
- wr_data_o  output  64  {slot[head][2*beat+1], slot[head][2*beat]}.
- wr_last_o  output  1  the current beat is the final beat of the head slot.
- wr_beat_i  input  1  write beat accepted by the bus this cycle.
- wr_done_o  output  1  one-cycle pulse after the head slot's last beat is accepted.
- level_o  output  2  number of non-EMPTY slots (0..2).
- err_o  output  1  sticky error: overflow, underflow or illegal word count.

Behaviour:
- All state changes on posedge clk_i; reset is checked first and is synchronous.
- Reset (reset_n_i=0):
  - All slots EMPTY; wr_ptr=0, rd_ptr=0, beat=0.
  - rd_ready_o=1, wr_req_o=0, wr_words_o=0, wr_data_o=0, wr_last_o=0, wr_done_o=0, level_o=0, err_o=0.
  - Slot data is not cleared.
  - Reset mid-drain abandons the slot with no wr_done_o.
- Per-slot state: EMPTY -> FULL (on capture) -> DRAINING (first accepted beat) -> EMPTY (last beat accepted). The encoding 2'b11 is illegal; if seen, the slot is forced EMPTY and err_o=1.
- Capture, when rd_done_i=1:
  - If slot[wr_ptr] is EMPTY and rd_words_i is in {2,6,8}: store rd_data_i and rd_words_i, slot becomes FULL, wr_ptr toggles. Visible on wr_req_o the next cycle (latency 1).
  - If the slot is not EMPTY: overflow. Data is dropped, err_o=1, pointers unchanged.
  - If rd_words_i is illegal: data is dropped, err_o=1.
- Drain:
  - Outputs come from slot[rd_ptr] and beat (2-bit counter).
  - wr_last_o = (beat == wr_words_o/2 - 1).
  - On wr_beat_i with head FULL/DRAINING: beat increments. If wr_last_o, beat=0, the slot goes EMPTY, rd_ptr toggles, and wr_done_o=1 on the next cycle.
  - wr_beat_i while the head is EMPTY: underflow, ignored, err_o=1.
- When wr_req_o=0: wr_data_o=0 and wr_last_o=0.
- Simultaneous capture and last beat on the same slot index: impossible, since the head is non-EMPTY.
- Simultaneous capture and last beat on different slots: both take effect; level_o is unchanged.
- Capture into the slot freed in the same cycle is not allowed; rd_ready_o reflects registered state.
- flush_i: all slots EMPTY, pointers and beat = 0, wr_done_o suppressed, err_o cleared. Flush has priority over same-cycle rd_done_i and wr_beat_i.
- level_o = count of non-EMPTY slots, registered.
- rd_ready_o = (level_o < 2).

Optional Feature:
- Macro: IP_CODMA_BUF_PARITY_EN.
- Defined:
  - One even-parity bit is stored per word at capture.
  - On each accepted beat, the parity of both words is checked.
  - A mismatch sets err_o and asserts an extra output port buf_parity_err_o (1 bit, one-cycle pulse, reset 0).
  - The beat still completes.
- Undefined: no parity storage, no buf_parity_err_o port; err_o is driven by overflow, underflow and illegal word count only.

Decomposition:
- Add to ip_codma_machine_states_pkg:
  - enum buf_slot_state_t {BUF_EMPTY, BUF_FULL, BUF_DRAINING, BUF_UNUSED}.
  - Constants BUF_NUM_SLOTS=2, BUF_WORDS=8, and legal word counts BUF_W2=2, BUF_W6=6, BUF_W8=8.
- One sub-module is natural: ip_codma_buf_slot.
  - Holds one 8x32 data register, the word count, the slot state and optional parity.
  - Interface: capture strobe, beat/last strobes, and read-out mux by beat.
  - The top instantiates two and owns the pointers, errors and level.

Test Plan:
- Reset then idle: reset_n_i=0 for 2 cycles -> rd_ready_o=1, level_o=0, wr_req_o=0, err_o=0.
- Single 8-word burst:
  - Stimulus: rd_done_i with words 0x0..0x7, rd_words_i=8, then wr_beat_i every cycle.
  - Response: wr_data_o = 0x00000001_00000000, then 0x..3_..2, 0x..5_..4, 0x..7_..6. wr_last_o on the 4th beat, wr_done_o one cycle later, level_o back to 0.
- Ping-pong overlap:
  - Stimulus: 6-word capture, then a 2-word capture on the same cycle as the first beat.
  - Response: level_o=2, rd_ready_o=0. After 3 beats the head switches to slot 1 with wr_words_o=2 and wr_last_o=1 on its first beat.
- Overflow: three rd_done_i pulses with no beats -> third data dropped, err_o=1, level_o=2.
- Underflow and illegal size: wr_beat_i with level_o=0 -> err_o=1. Then flush_i -> err_o=0. Then rd_words_i=5 -> err_o=1 and no capture.
- Flush mid-drain: flush_i after beat 1 of an 8-word slot -> next cycle wr_req_o=0, level_o=0, no wr_done_o pulse.
